// File: rtl/cam_stream_pkg.sv
// Shared definitions for the 4-bit camera-port packet stream (serializer and receiver).
package cam_stream_pkg;

    localparam int NIBBLES_PER_PKT = 8;

    localparam int FLAG_RW_N     = 7;
    localparam int FLAG_M2SEL_N  = 6;
    localparam int FLAG_M2B0     = 5;
    localparam int FLAG_SW_GS    = 4;
    localparam int FLAG_RESET    = 0;

    localparam logic [7:0] HEARTBEAT_FLAGS = 8'hAA;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  flags;
    } cam_pkt_t;

    typedef struct packed {
        cam_pkt_t pkt;
        logic     is_reset;
        logic     is_heartbeat;
    } cam_entry_t;

    localparam int ENTRY_W = $bits(cam_entry_t);

endpackage

// File: rtl/cam_rx_fifo.sv
// Synchronous FIFO; a pop in the same cycle frees the slot for a push into a full buffer.
module cam_rx_fifo #(
    parameter int DATA_W = 34,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic              push_ok
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_pop;
    logic              do_push;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign push_ok  = do_push;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cam_stream_receiver.sv
// Recovers 32-bit packets from the oversampled camera-port nibble stream, classifies
// them and buffers them behind a valid/ready handshake with framing/drop/heartbeat stats.
module cam_stream_receiver
    import cam_stream_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] HB_ADDR    = 16'hC0FF
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        cam_pclk,
    input  logic        cam_sync,
    input  logic [3:0]  cam_data,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [15:0] pkt_addr,
    output logic [7:0]  pkt_data,
    output logic [7:0]  pkt_flags,
    output logic        pkt_is_reset,
    output logic        pkt_is_heartbeat,
    output logic [15:0] rx_count,
    output logic [15:0] frame_err_count,
    output logic [15:0] drop_count,
    output logic        hb_seq_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic       pclk_meta, pclk_sync, pclk_dly;
    logic       sync_meta, sync_sync;
    logic [3:0] data_meta, data_sync;
    logic       beat_stb;
    logic       sync_s;
    logic [3:0] data_s;

    logic [0:0]  state;
    logic [2:0]  nib_cnt;
    logic [31:0] shreg;
    logic        last_beat;
    logic        push_p1;
    logic [31:0] word_p1;
    cam_entry_t  entry_p1;
    cam_entry_t  head;

    logic fifo_full, fifo_empty, fifo_push_ok, fifo_pop;

    logic [7:0] hb_exp;
    logic       hb_exp_vld;

    // Stage p0: two-flop synchronizers, third pclk flop for edge detect, beat-aligned sample
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pclk_meta <= 1'b0;
            pclk_sync <= 1'b0;
            pclk_dly  <= 1'b0;
            sync_meta <= 1'b0;
            sync_sync <= 1'b0;
            data_meta <= '0;
            data_sync <= '0;
            beat_stb  <= 1'b0;
            sync_s    <= 1'b0;
            data_s    <= '0;
        end else begin
            pclk_meta <= cam_pclk;
            pclk_sync <= pclk_meta;
            pclk_dly  <= pclk_sync;
            sync_meta <= cam_sync;
            sync_sync <= sync_meta;
            data_meta <= cam_data;
            data_sync <= data_meta;
            beat_stb  <= pclk_sync & ~pclk_dly;
            sync_s    <= sync_sync;
            data_s    <= data_sync;
        end
    end

    assign last_beat = (state == ST_RECV) && sync_s && beat_stb &&
                       (nib_cnt == 3'(NIBBLES_PER_PKT - 1));

    // Stage p1: nibble assembly FSM
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            nib_cnt         <= '0;
            shreg           <= '0;
            push_p1         <= 1'b0;
            frame_err_count <= '0;
        end else begin
            push_p1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (beat_stb && sync_s) begin
                        shreg   <= {shreg[27:0], data_s};
                        nib_cnt <= 3'd1;
                        state   <= ST_RECV;
                    end
                end
                default: begin
                    if (!sync_s) begin
                        frame_err_count <= sat_inc(frame_err_count);
                        nib_cnt         <= '0;
                        shreg           <= '0;
                        state           <= ST_IDLE;
                    end else if (beat_stb) begin
                        shreg <= {shreg[27:0], data_s};
                        if (last_beat) begin
                            nib_cnt <= '0;
                            push_p1 <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            nib_cnt <= nib_cnt + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (last_beat) begin
            word_p1 <= {shreg[27:0], data_s};
        end
    end

    always_comb begin
        entry_p1              = '0;
        entry_p1.pkt          = word_p1;
        entry_p1.is_reset     = word_p1[FLAG_RESET];
        entry_p1.is_heartbeat = (word_p1[31:16] == HB_ADDR) && (word_p1[7:0] == HEARTBEAT_FLAGS);
    end

    assign fifo_pop = pkt_valid & pkt_ready;

    cam_rx_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .push      (push_p1),
        .push_data (entry_p1),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_ok   (fifo_push_ok)
    );

    // Stage p2: statistics and heartbeat continuity, evaluated as each packet completes
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_count   <= '0;
            drop_count <= '0;
            hb_seq_err <= 1'b0;
            hb_exp     <= '0;
            hb_exp_vld <= 1'b0;
        end else begin
            hb_seq_err <= 1'b0;
            if (fifo_push_ok) begin
                rx_count <= sat_inc(rx_count);
            end
            if (push_p1 && fifo_full && !fifo_pop) begin
                drop_count <= sat_inc(drop_count);
            end
            if (push_p1) begin
                if (entry_p1.is_reset) begin
                    hb_exp_vld <= 1'b0;
                end else if (entry_p1.is_heartbeat) begin
                    hb_seq_err <= hb_exp_vld && (entry_p1.pkt.data != hb_exp);
                    hb_exp     <= entry_p1.pkt.data + 8'd1;
                    hb_exp_vld <= 1'b1;
                end
            end
        end
    end

    assign pkt_valid        = ~fifo_empty;
    assign pkt_addr         = pkt_valid ? head.pkt.addr  : '0;
    assign pkt_data         = pkt_valid ? head.pkt.data  : '0;
    assign pkt_flags        = pkt_valid ? head.pkt.flags : '0;
    assign pkt_is_reset     = pkt_valid & head.is_reset;
    assign pkt_is_heartbeat = pkt_valid & head.is_heartbeat;

endmodule

// File: doc/cam_stream_receiver.md
# cam_stream_receiver

Receiving end of the 4-bit camera-port packet stream produced by the bus-capture serializer. Recovers the 32-bit packets from cam_pclk/cam_sync/cam_data, oversampled in the local clock domain. Splits each packet into address, data and flags, and classifies reset-indicator and heartbeat packets. Buffers packets in a small FIFO behind a valid/ready handshake, and keeps framing, drop and heartbeat-sequence statistics. Used on the loopback/test FPGA build and as the reference decoder in stream benches.

## Interface
- FIFO_DEPTH, 4: packet buffer depth; power of 2, ≥2.
- HB_ADDR, 16'hC0FF: address that identifies a heartbeat packet.
- clk_i  in  1  local logic clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- cam_pclk  in  1  stream beat clock, asynchronous to clk_i.
- cam_sync  in  1  frame-active qualifier.
- cam_data  in  4  nibble.
- pkt_valid  out  1  packet available at FIFO head.
- pkt_ready  in  1  consumer accepts head when high with pkt_valid.
- pkt_addr  out  16  packet bits [31:16].
- pkt_data  out  8  packet bits [15:8].
- pkt_flags  out  8  packet bits [7:0]: [7] rw_n, [6] m2sel_n, [5] m2b0, [4] sw_gs, [0] reset indicator.
- pkt_is_reset  out  1  flags[0]==1.
- pkt_is_heartbeat  out  1  pkt_addr==HB_ADDR and flags==8'hAA.
- rx_count  out  16  packets pushed into the FIFO.
- frame_err_count  out  16  aborted partial frames.
- drop_count  out  16  complete packets lost to a full FIFO.
- hb_seq_err  out  1  one-cycle pulse on a heartbeat counter discontinuity.

## Operation
- Input conditioning: cam_pclk, cam_sync and cam_data each pass through 2-flop synchronizers. A third pclk flop detects the rising edge.
- beat_stb is high for one cycle per synchronized pclk rise. sync_s and data_s are sampled on beat_stb.
- Wire format: 8 nibbles per packet, MSB nibble first. Every beat carries cam_sync=1. Back-to-back packets may keep sync high continuously.
- FSM IDLE/RECV with a 3-bit nibble counter:
  - IDLE: beat_stb with sync_s=1 → shift the nibble in, counter=1, go to RECV.
  - RECV: beat_stb with sync_s=1 → shift the nibble in, counter+1. On the 8th nibble, counter wraps to 0, the assembled word is pushed, and the FSM goes to IDLE.
  - RECV: sync_s low on any clk_i cycle (beat or not) → frame_err_count++, counter=0, shift register cleared, go to IDLE.
  - IDLE ignores beats with sync_s=0.
- Classification is computed on push and stored in the FIFO with the packet.
- Heartbeat check:
  - The first heartbeat after reset, or after a reset-indicator packet, loads the expected counter with data+1. No error is raised.
  - Each later heartbeat with data≠expected pulses hb_seq_err. Expected is then reloaded with data+1, mod 256.
- FIFO:
  - Push on frame completion.
  - If full, the packet is dropped and drop_count++.
  - A pop (pkt_valid & pkt_ready) in the same cycle as a push into a full FIFO frees the slot, so the push is accepted.
- Output fields are driven from the FIFO head and are stable while pkt_valid=1 and pkt_ready=0.
- All counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - pkt_valid=0; pkt_addr, pkt_data and pkt_flags = 0; pkt_is_reset and pkt_is_heartbeat = 0.
  - All counters 0; hb_seq_err=0; FSM in IDLE; counter 0; FIFO empty; heartbeat expectation invalid; synchronizers 0.
- Input constraint: each cam_pclk high and low phase lasts ≥3 clk_i cycles. cam_sync and cam_data are stable for ≥3 clk_i cycles around the pclk rise.
- Latency: beat_stb fires 3 clk_i cycles after pclk rises at the pin. The push happens 1 cycle after the 8th beat_stb. pkt_valid rises 1 cycle after the push when the FIFO was empty. Total: 5 cycles from the 8th pclk rise.
- Throughput: one pop per cycle.
- Reset asserted mid-frame discards the partial frame and all FIFO contents. frame_err_count is not incremented.

## Structure
- Package cam_stream_pkg holds:
  - the packed packet struct (addr, data, flags);
  - flag bit index constants;
  - the HEARTBEAT_FLAGS=8'hAA constant;
  - NIBBLES_PER_PKT=8.
- The serializer side imports the same package.
- Sub-module cam_rx_fifo: synchronous FIFO parameterized by width and depth, with full/empty flags and same-cycle push/pop when full.

## Test plan
- Single packet 32'h1234_5680, sent with pclk at clk_i/8 → pkt_addr=16'h1234, pkt_data=8'h56, pkt_flags=8'h80, pkt_valid 5 cycles after the 8th rise, rx_count=1.
- Reset packet 32'h0000_0001, then heartbeats with data 00, 01, 02, 04 → pkt_is_reset=1 on the first packet, pkt_is_heartbeat=1 on the rest, exactly one hb_seq_err pulse (on data 04).
- Sync dropped after 5 nibbles, then a full packet 32'hC030_FF80 → frame_err_count=1, only C030/FF/80 delivered.
- 6 back-to-back packets with sync held high and pkt_ready=0, FIFO_DEPTH=4 → 4 buffered, drop_count=2; packets drain in order once pkt_ready=1.
- FIFO full, a pop and a push in the same cycle → push accepted, drop_count unchanged.
- rst_n pulsed low after 3 nibbles → all outputs at reset values; the next full packet is received correctly; frame_err_count=0.
